stack_regfile: RTL and testbench
================================

// Module: stack_regfile
// PURPOSE
//   Parametrised successor to the single-port-pair register file: a stack-organised
//   memory with push/pop, in-place random write, and NUM_RD independent random read
//   channels. Reads are registered and tagged with address and valid.
//   Out-of-range access and overflow/underflow are flagged, not silently dropped.
//   Sits between the accelerator's result producers (push) and compute lanes (random reads).
// PARAMETERS
//   DATA_WIDTH  8   width of one entry
//   ADDR_WIDTH  12  address width; DEPTH = 2**ADDR_WIDTH entries (local)
//   NUM_RD      2   number of random read channels (>=1)
// PORTS
//   clk        in   1                    clock, all state on rising edge
//   rst_n      in   1                    asynchronous active-low reset
//   clr        in   1                    sync clear: count and sticky flags to 0
//   push       in   1                    append push_data at index count
//   push_data  in   DATA_WIDTH           data for push
//   pop        in   1                    remove top entry
//   wr_en      in   1                    random write enable
//   wr_addr    in   ADDR_WIDTH           random write address
//   wr_data    in   DATA_WIDTH           random write data
//   top_re     in   1                    read top-of-stack
//   top_data   out  DATA_WIDTH           registered top data
//   top_addr   out  ADDR_WIDTH           address of top_data
//   top_valid  out  1                    top_data/top_addr meaningful
//   rd_en      in   NUM_RD               per-channel read enable
//   rd_addr    in   NUM_RD*ADDR_WIDTH    channel i at [i*AW +: AW]
//   rd_data    out  NUM_RD*DATA_WIDTH    channel i at [i*DW +: DW]
//   rd_addr_o  out  NUM_RD*ADDR_WIDTH    echoed address per channel
//   rd_valid   out  NUM_RD               per-channel valid
//   count      out  ADDR_WIDTH+1         entries held, 0..DEPTH
//   empty/full out  1                    count==0 / count==DEPTH (combinational from count)
//   ovf/udf    out  1                    sticky overflow / underflow, cleared by clr or reset
// BEHAVIOUR
// - Reset (async): count=0; ovf=udf=0; all data/addr/valid outputs 0. Memory contents are not reset.
// - Priority per edge: clr > push/pop > wr_en. clr suppresses push, pop and wr_en that cycle.
// - Push only: if !full, mem[count]<=push_data, count+1. If full, ignored and ovf<=1.
// - Pop only: if !empty, count-1. If empty, ignored and udf<=1.
// - Push+pop same cycle:
//     non-empty: replace top, mem[count-1]<=push_data, count unchanged;
//     empty: plain push.
// - wr_en: writes mem[wr_addr] only if wr_addr < count (pre-edge).
//   Otherwise ignored, no flag.
//   If the same edge's push/replace targets wr_addr, push data wins.
// - Reads have 1-cycle latency; all outputs are registered.
//   Read data, address and range are sampled from pre-edge state (read-before-write).
// - Channel i valid when rd_en[i] && rd_addr_i < count (pre-edge):
//   next cycle rd_valid[i]=1, rd_data=mem[addr], rd_addr_o=addr.
//   Otherwise rd_valid[i]=0 and data/addr are driven 0, never Z.
// - Top read: valid when top_re && !empty (pre-edge): top_data=mem[count-1], top_addr=count-1.
//   Otherwise outputs 0 and top_valid=0.
// - count never wraps; it is held at DEPTH or 0 on illegal operations.
// - Reset asserted mid-operation clears state immediately.
//   Operations in flight are lost; rd_valid/top_valid drop asynchronously.
// TESTING
// - Reset, push 0x11,0x22,0x33 -> count=3; top_re next cycle -> top_data=0x33, top_addr=2, top_valid=1.
// - count=3, rd_en=2'b11, addr0=1, addr1=3 -> next cycle ch0 valid with 0x22/addr 1;
//   ch1 valid=0, data=0, addr=0.
// - count=3, push 0x44 + pop same cycle -> count=3, mem[2]=0x44; then pop on empty -> udf=1 until clr.
// - Fill to DEPTH (ADDR_WIDTH=4, 16 pushes) -> full=1; 17th push -> count=16, ovf=1, mem unchanged.
// - count=2, wr_en addr 1 data 0xAA + rd_en ch0 addr 1 same edge -> rd_data=old value;
//   next read gives 0xAA. wr_addr 5 -> ignored.
// - count=4 with pending reads, assert rst_n low mid-cycle -> count=0, all valids 0 without a clock edge.

Source files
------------

// File: rtl/stack_regfile.sv
// Stack-organised register file: push/pop/replace at the top, in-place random write,
// NUM_RD registered random read channels plus a registered top-of-stack read.
module stack_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         top_re,
  output logic [DATA_WIDTH-1:0]        top_data,
  output logic [ADDR_WIDTH-1:0]        top_addr,
  output logic                         top_valid,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_o,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf,
  output logic                         udf
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] push_idx;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  push_we;
  logic                  wr_ok;
  logic                  set_ovf;
  logic                  set_udf;
  logic                  top_ok;
  logic [NUM_RD-1:0]     rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  // Wraps to DEPTH-1 when full, which is exactly the top index in that case.
  assign top_idx = count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_comb begin
    push_we    = 1'b0;
    push_idx   = '0;
    next_count = count;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (push && pop && !empty) begin
      push_we  = 1'b1;
      push_idx = top_idx;
    end else if (push) begin
      if (!full) begin
        push_we    = 1'b1;
        push_idx   = count[ADDR_WIDTH-1:0];
        next_count = count + (ADDR_WIDTH+1)'(1);
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pop) begin
      if (!empty) next_count = count - (ADDR_WIDTH+1)'(1);
      else        set_udf    = 1'b1;
    end
    wr_ok  = !clr && wr_en && ({1'b0, wr_addr} < count);
    top_ok = top_re && !empty;
    rd_ok  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_ok[i] = rd_en[i] && ({1'b0, rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < count);
    end
  end

  // Push is written after the random write so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (wr_ok)   mem[wr_addr]  <= wr_data;
    if (push_we) mem[push_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      top_valid <= 1'b0;
      top_data  <= '0;
      top_addr  <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      rd_addr_o <= '0;
    end else begin
      count     <= next_count;
      ovf       <= clr ? 1'b0 : (ovf | set_ovf);
      udf       <= clr ? 1'b0 : (udf | set_udf);
      top_valid <= top_ok;
      top_data  <= top_ok ? mem[top_idx] : '0;
      top_addr  <= top_ok ? top_idx : '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_valid[i] <= rd_ok[i];
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] <=
          rd_ok[i] ? mem[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
        rd_addr_o[i*ADDR_WIDTH +: ADDR_WIDTH] <=
          rd_ok[i] ? rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      end
    end
  end

endmodule

// File: tb/tb_stack_regfile.sv
// Bench for stack_regfile (16 entries, 2 read channels): directed vector table,
// hand-written fill/overflow and async-reset sequences, then random traffic vs a queue model.
module tb_stack_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr, push, pop, wr_en, top_re;
  logic [7:0]  push_data, wr_data, top_data;
  logic [3:0]  wr_addr, top_addr;
  logic        top_valid, empty, full, ovf, udf;
  logic [1:0]  rd_en, rd_valid;
  logic [7:0]  rd_addr, rd_addr_o;
  logic [15:0] rd_data;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(push), .push_data(push_data), .pop(pop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .top_re(top_re), .top_data(top_data), .top_addr(top_addr), .top_valid(top_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_addr_o(rd_addr_o),
    .rd_valid(rd_valid), .count(count), .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  typedef struct packed {
    logic       clr, push;
    logic [7:0] pd;
    logic       pop, wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       top_re;
    logic [1:0] rd_en;
    logic [3:0] ra0, ra1;
  } in_t;

  typedef struct packed {
    logic [4:0] count;
    logic       tv;
    logic [7:0] td;
    logic [3:0] ta;
    logic [1:0] rv;
    logic [7:0] rd0;
    logic [3:0] ao0;
    logic [7:0] rd1;
    logic [3:0] ao1;
    logic       ovf, udf;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input in_t x);
    clr = x.clr; push = x.push; push_data = x.pd; pop = x.pop;
    wr_en = x.wr; wr_addr = x.wa; wr_data = x.wd;
    top_re = x.top_re; rd_en = x.rd_en; rd_addr = {x.ra1, x.ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    chk({tag, " count"},     32'(count),          32'(e.count));
    chk({tag, " empty"},     32'(empty),          32'(e.count == 0));
    chk({tag, " full"},      32'(full),           32'(e.count == 16));
    chk({tag, " ovf"},       32'(ovf),            32'(e.ovf));
    chk({tag, " udf"},       32'(udf),            32'(e.udf));
    chk({tag, " top_valid"}, 32'(top_valid),      32'(e.tv));
    chk({tag, " top_data"},  32'(top_data),       32'(e.td));
    chk({tag, " top_addr"},  32'(top_addr),       32'(e.ta));
    chk({tag, " rd_valid"},  32'(rd_valid),       32'(e.rv));
    chk({tag, " rd_data0"},  32'(rd_data[7:0]),   32'(e.rd0));
    chk({tag, " rd_addr0"},  32'(rd_addr_o[3:0]), 32'(e.ao0));
    chk({tag, " rd_data1"},  32'(rd_data[15:8]),  32'(e.rd1));
    chk({tag, " rd_addr1"},  32'(rd_addr_o[7:4]), 32'(e.ao1));
  endtask

  // Reference: the stack is a queue; index k is the k-th entry from the bottom.
  task automatic model_step(input in_t x, output exp_t e);
    int sz;
    sz = q.size();
    e = '0;
    if (x.top_re && sz > 0) begin
      e.tv = 1'b1; e.td = q[sz-1]; e.ta = 4'(sz - 1);
    end
    if (x.rd_en[0] && int'(x.ra0) < sz) begin
      e.rv[0] = 1'b1; e.rd0 = q[x.ra0]; e.ao0 = x.ra0;
    end
    if (x.rd_en[1] && int'(x.ra1) < sz) begin
      e.rv[1] = 1'b1; e.rd1 = q[x.ra1]; e.ao1 = x.ra1;
    end
    if (x.clr) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (x.wr && int'(x.wa) < sz) q[x.wa] = x.wd;
      if (x.push && x.pop && sz > 0) q[sz-1] = x.pd;
      else if (x.push) begin
        if (sz < 16) q.push_back(x.pd);
        else m_ovf = 1'b1;
      end else if (x.pop) begin
        if (sz > 0) void'(q.pop_back());
        else m_udf = 1'b1;
      end
    end
    e.count = 5'(q.size());
    e.ovf = m_ovf;
    e.udf = m_udf;
  endtask

  function automatic vec_t mkv(
    input int c, p, pd, po, w, wa, wd, tre, rde, ra0, ra1,
    input int cnt, tv, td, ta, rv, rd0, ao0, rd1, ao1, ov, ud);
    vec_t r;
    r.i.clr = 1'(c);  r.i.push = 1'(p);  r.i.pd = 8'(pd); r.i.pop = 1'(po);
    r.i.wr = 1'(w);   r.i.wa = 4'(wa);   r.i.wd = 8'(wd); r.i.top_re = 1'(tre);
    r.i.rd_en = 2'(rde); r.i.ra0 = 4'(ra0); r.i.ra1 = 4'(ra1);
    r.e.count = 5'(cnt); r.e.tv = 1'(tv); r.e.td = 8'(td); r.e.ta = 4'(ta);
    r.e.rv = 2'(rv); r.e.rd0 = 8'(rd0); r.e.ao0 = 4'(ao0);
    r.e.rd1 = 8'(rd1); r.e.ao1 = 4'(ao1); r.e.ovf = 1'(ov); r.e.udf = 1'(ud);
    return r;
  endfunction

  vec_t tbl[21];
  in_t  x;
  exp_t e;

  initial begin
    //            clr psh pd   pop wr wa wd  tre rde ra0 ra1  cnt tv td   ta rv rd0  ao0 rd1 ao1 ov ud
    tbl[0]  = mkv(0, 1, 'h11, 0, 0, 0, 0,    0, 0, 0, 0,    1, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 1, 'h22, 0, 0, 0, 0,    0, 0, 0, 0,    2, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 'h33, 0, 0, 0, 0,    0, 0, 0, 0,    3, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 0, 0,    0, 0, 0, 0,    1, 0, 0, 0,    3, 1, 'h33, 2, 0, 0,    0, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 0,    0, 0, 0, 0,    0, 3, 1, 3,    3, 0, 0,    0, 1, 'h22, 1, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 1, 'h44, 1, 0, 0, 0,    0, 0, 0, 0,    3, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0,    0, 0, 0, 0,    1, 1, 2, 0,    3, 1, 'h44, 2, 1, 'h44, 2, 0, 0, 0, 0);
    tbl[7]  = mkv(0, 0, 0,    0, 1, 1, 'hAA, 0, 1, 1, 0,    3, 0, 0,    0, 1, 'h22, 1, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 0,    0, 0, 0, 0,    0, 1, 1, 0,    3, 0, 0,    0, 1, 'hAA, 1, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 0, 0,    0, 1, 5, 'h55, 0, 3, 0, 5,    3, 0, 0,    0, 1, 'h11, 0, 0, 0, 0, 0);
    tbl[10] = mkv(0, 0, 0,    1, 0, 0, 0,    0, 0, 0, 0,    2, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[11] = mkv(0, 0, 0,    1, 0, 0, 0,    0, 0, 0, 0,    1, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[12] = mkv(0, 0, 0,    1, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[13] = mkv(0, 0, 0,    1, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 1);
    tbl[14] = mkv(0, 0, 0,    0, 0, 0, 0,    1, 3, 0, 0,    0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 1);
    tbl[15] = mkv(1, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[16] = mkv(0, 1, 'h77, 1, 0, 0, 0,    0, 0, 0, 0,    1, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[17] = mkv(0, 0, 0,    0, 0, 0, 0,    1, 0, 0, 0,    1, 1, 'h77, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[18] = mkv(0, 1, 'h99, 1, 1, 0, 'h11, 0, 0, 0, 0,    1, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);
    tbl[19] = mkv(0, 0, 0,    0, 0, 0, 0,    1, 1, 0, 0,    1, 1, 'h99, 0, 1, 'h99, 0, 0, 0, 0, 0);
    tbl[20] = mkv(1, 1, 'h05, 0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0,    0, 0, 0,    0, 0, 0, 0, 0);

    x = '0;
    drive(x);
    #12;
    check_exp("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].i);
      tick();
      check_exp($sformatf("vec%0d", k), tbl[k].e);
    end

    // Fill to DEPTH, then one more push must flag overflow and leave contents intact.
    for (int k = 0; k < 16; k++) begin
      x = '0; x.push = 1'b1; x.pd = 8'(8'hA0 + k);
      drive(x);
      tick();
    end
    chk("fill count", 32'(count), 32'd16);
    chk("fill full",  32'(full),  32'd1);
    chk("fill ovf",   32'(ovf),   32'd0);
    x = '0; x.push = 1'b1; x.pd = 8'hEE;
    drive(x);
    tick();
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf flag",  32'(ovf),   32'd1);
    x = '0; x.top_re = 1'b1; x.rd_en = 2'b11; x.ra0 = 4'd15; x.ra1 = 4'd0;
    drive(x);
    tick();
    chk("ovf top_data", 32'(top_data),      32'hAF);
    chk("ovf top_addr", 32'(top_addr),      32'd15);
    chk("ovf rd_data0", 32'(rd_data[7:0]),  32'hAF);
    chk("ovf rd_data1", 32'(rd_data[15:8]), 32'hA0);
    chk("ovf sticky",   32'(ovf),           32'd1);
    x = '0; x.clr = 1'b1;
    drive(x);
    tick();
    chk("clr ovf",   32'(ovf),   32'd0);
    chk("clr count", 32'(count), 32'd0);

    // Asynchronous reset with reads in flight.
    for (int k = 0; k < 4; k++) begin
      x = '0; x.push = 1'b1; x.pd = 8'(8'hC0 + k);
      drive(x);
      tick();
    end
    x = '0; x.top_re = 1'b1; x.rd_en = 2'b11; x.ra0 = 4'd0; x.ra1 = 4'd3;
    drive(x);
    tick();
    chk("pre-rst top_valid", 32'(top_valid), 32'd1);
    chk("pre-rst top_data",  32'(top_data),  32'hC3);
    chk("pre-rst rd_valid",  32'(rd_valid),  32'd3);
    chk("pre-rst count",     32'(count),     32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async count",     32'(count),     32'd0);
    chk("async empty",     32'(empty),     32'd1);
    chk("async top_valid", 32'(top_valid), 32'd0);
    chk("async top_data",  32'(top_data),  32'd0);
    chk("async rd_valid",  32'(rd_valid),  32'd0);
    chk("async rd_data",   32'(rd_data),   32'd0);
    x = '0;
    drive(x);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;

    // Random traffic, alternating push-heavy and pop-heavy phases to reach both ends.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int push_pct;
      push_pct = ((cyc / 250) % 2 == 0) ? 70 : 30;
      x.clr    = ($urandom_range(0, 199) == 0);
      x.push   = ($urandom_range(0, 99) < push_pct);
      x.pop    = ($urandom_range(0, 99) < (100 - push_pct));
      x.pd     = 8'($urandom);
      x.wr     = ($urandom_range(0, 99) < 30);
      x.wa     = 4'($urandom_range(0, 15));
      x.wd     = 8'($urandom);
      x.top_re = 1'($urandom);
      x.rd_en  = 2'($urandom);
      x.ra0    = 4'($urandom_range(0, 15));
      x.ra1    = 4'($urandom_range(0, 15));
      model_step(x, e);
      drive(x);
      tick();
      check_exp($sformatf("rand%0d", cyc), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
